ctrl_pipeline: RTL and testbench

Carries the 12-bit control word from the instruction decoder through the EX, MEM and WB pipeline stages. It also owns the pipeline's hazard logic: load-use stall, branch/jump flush, and forwarding selects for the EX-stage ALU operands. It sits between the ID-stage decoder and the datapath, and is the consumer of every control field the decoder produces.

---
 rtl/ctrl_pipeline.sv | 166 ++++++++++++++++
 tb/tb_ctrl_pipeline.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline
//   Carries the decoder's 12-bit control word through the EX, MEM and WB
//   stages and owns the pipeline hazard logic:
//     - load-use stall (one bubble inserted into EX)
//     - branch/jump flush of IF/ID (redirect beats stall)
//     - forwarding selects for the two EX-stage ALU operands
//
//   Control word layout (ctrl_id):
//     [11] RegWrite  [10:9] DataSel  [8] MemRead  [7] MemWrite
//     [6:4] AddrSel  [3:1] ALUOperator  [0] ALUSel
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   ctrl_id                     decoder control word (ID stage)
//   rs1_id, rs2_id, rd_id       ID-stage register fields
//   redirect_ex                 EX-stage branch taken / jal / jalr
//   ex_alu_op, ex_alu_sel       EX control: ALU operator and operand select
//   ex_addr_sel                 EX control: address select
//   mem_read, mem_write         MEM control
//   wb_reg_write, wb_data_sel   WB control
//   ex_rd, mem_rd, wb_rd        destination register per stage
//   stall                       hold PC and IF/ID this cycle
//   flush_ifid                  squash IF/ID this cycle
//   fwd_a, fwd_b                EX operand source: 00 RF, 01 MEM, 10 WB

module ctrl_pipeline #(
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [11:0]       ctrl_id,
  input  logic [REG_AW-1:0] rs1_id,
  input  logic [REG_AW-1:0] rs2_id,
  input  logic [REG_AW-1:0] rd_id,
  input  logic              redirect_ex,
  output logic [2:0]        ex_alu_op,
  output logic              ex_alu_sel,
  output logic [2:0]        ex_addr_sel,
  output logic              mem_read,
  output logic              mem_write,
  output logic              wb_reg_write,
  output logic [1:0]        wb_data_sel,
  output logic [REG_AW-1:0] ex_rd,
  output logic [REG_AW-1:0] mem_rd,
  output logic [REG_AW-1:0] wb_rd,
  output logic              stall,
  output logic              flush_ifid,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Each stage keeps only the control fields it or a later stage consumes:
  //   EX  : full word [11:0]
  //   MEM : [11:7]  -> {RegWrite, DataSel, MemRead, MemWrite}
  //   WB  : [11:9]  -> {RegWrite, DataSel}
  localparam int MEM_CW = 5;
  localparam int WB_CW  = 3;

  logic [11:0]       ex_ctrl_q,  ex_ctrl_d;
  logic [REG_AW-1:0] ex_rs1_q,   ex_rs1_d;
  logic [REG_AW-1:0] ex_rs2_q,   ex_rs2_d;
  logic [REG_AW-1:0] ex_rd_q,    ex_rd_d;
  logic [MEM_CW-1:0] mem_ctrl_q, mem_ctrl_d;
  logic [REG_AW-1:0] mem_rd_q,   mem_rd_d;
  logic [WB_CW-1:0]  wb_ctrl_q,  wb_ctrl_d;
  logic [REG_AW-1:0] wb_rd_q,    wb_rd_d;

  logic luh;
  logic squash_ex;
  logic mem_reg_write;

  // Forwarding source for one EX operand. MEM is newer than WB, so it wins.
  // Register 0 is hard-wired and never forwarded.
  function automatic logic [1:0] fwd_src(
    input logic [REG_AW-1:0] rs,
    input logic              m_we,
    input logic [REG_AW-1:0] m_rd,
    input logic              w_we,
    input logic [REG_AW-1:0] w_rd
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (m_we && (m_rd != '0) && (m_rd == rs))
      sel = FWD_MEM;
    else if (w_we && (w_rd != '0) && (w_rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  assign mem_reg_write = mem_ctrl_q[MEM_CW-1];

  always_comb begin
    // Conservative load-use check: both rs fields are compared whether or
    // not the ID instruction actually reads them.
    luh = ex_ctrl_q[8] & (ex_rd_q != '0) &
          ((ex_rd_q == rs1_id) | (ex_rd_q == rs2_id));

    // A redirect wins over a stall: the stalled instruction is on the wrong
    // path and is being flushed anyway.
    flush_ifid = redirect_ex;
    stall      = luh & ~redirect_ex;
    squash_ex  = redirect_ex | luh;

    if (squash_ex) begin
      ex_ctrl_d = '0;
      ex_rs1_d  = '0;
      ex_rs2_d  = '0;
      ex_rd_d   = '0;
    end else begin
      ex_ctrl_d = ctrl_id;
      ex_rs1_d  = rs1_id;
      ex_rs2_d  = rs2_id;
      ex_rd_d   = rd_id;
    end

    // MEM and WB advance unconditionally; a load in EX during a redirect
    // still proceeds into MEM.
    mem_ctrl_d = ex_ctrl_q[11:7];
    mem_rd_d   = ex_rd_q;
    wb_ctrl_d  = mem_ctrl_q[MEM_CW-1:MEM_CW-WB_CW];
    wb_rd_d    = mem_rd_q;

    fwd_a = fwd_src(ex_rs1_q, mem_reg_write, mem_rd_q,
                    wb_ctrl_q[WB_CW-1], wb_rd_q);
    fwd_b = fwd_src(ex_rs2_q, mem_reg_write, mem_rd_q,
                    wb_ctrl_q[WB_CW-1], wb_rd_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_ctrl_q  <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd_q    <= '0;
      mem_ctrl_q <= '0;
      mem_rd_q   <= '0;
      wb_ctrl_q  <= '0;
      wb_rd_q    <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd_q    <= ex_rd_d;
      mem_ctrl_q <= mem_ctrl_d;
      mem_rd_q   <= mem_rd_d;
      wb_ctrl_q  <= wb_ctrl_d;
      wb_rd_q    <= wb_rd_d;
    end
  end

  assign ex_alu_op    = ex_ctrl_q[3:1];
  assign ex_alu_sel   = ex_ctrl_q[0];
  assign ex_addr_sel  = ex_ctrl_q[6:4];
  assign ex_rd        = ex_rd_q;
  assign mem_read     = mem_ctrl_q[1];
  assign mem_write    = mem_ctrl_q[0];
  assign mem_rd       = mem_rd_q;
  assign wb_reg_write = wb_ctrl_q[2];
  assign wb_data_sel  = wb_ctrl_q[1:0];
  assign wb_rd        = wb_rd_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
module tb_ctrl_pipeline;

  localparam int AW = 5;
  localparam logic [11:0] ADD = 12'h803;
  localparam logic [11:0] LW  = 12'hD02;
  localparam logic [11:0] NOP = 12'h000;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [11:0]   ctrl_id;
  logic [AW-1:0] rs1_id, rs2_id, rd_id;
  logic          redirect_ex;
  logic [2:0]    ex_alu_op, ex_addr_sel;
  logic          ex_alu_sel, mem_read, mem_write, wb_reg_write;
  logic [1:0]    wb_data_sel, fwd_a, fwd_b;
  logic [AW-1:0] ex_rd, mem_rd, wb_rd;
  logic          stall, flush_ifid;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.REG_AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .ctrl_id(ctrl_id),
    .rs1_id(rs1_id), .rs2_id(rs2_id), .rd_id(rd_id),
    .redirect_ex(redirect_ex),
    .ex_alu_op(ex_alu_op), .ex_alu_sel(ex_alu_sel), .ex_addr_sel(ex_addr_sel),
    .mem_read(mem_read), .mem_write(mem_write),
    .wb_reg_write(wb_reg_write), .wb_data_sel(wb_data_sel),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .stall(stall), .flush_ifid(flush_ifid), .fwd_a(fwd_a), .fwd_b(fwd_b)
  );

  // ---------------- directed vector table ----------------
  typedef struct {
    logic          rst;
    logic [11:0]   c;
    logic [AW-1:0] s1, s2, d;
    logic          redir;
    logic [26:0]   exp;  // {op,sel,mem_read,wb_rw,ex_rd,mem_rd,wb_rd,stall,flush,fa,fb}
  } vec_t;

  localparam int NV = 26;
  vec_t vecs[NV];

  function automatic vec_t mk(input logic rst, input logic [11:0] c,
                              input int s1, input int s2, input int d,
                              input logic redir,
                              input int op, input int sel, input int mr,
                              input int wr, input int erd, input int mrd,
                              input int wrd, input int st, input int fl,
                              input int fa, input int fb);
    vec_t v;
    v.rst = rst; v.c = c; v.redir = redir;
    v.s1 = AW'(s1); v.s2 = AW'(s2); v.d = AW'(d);
    v.exp = {3'(op), 1'(sel), 1'(mr), 1'(wr), AW'(erd), AW'(mrd), AW'(wrd),
             1'(st), 1'(fl), 2'(fa), 2'(fb)};
    return v;
  endfunction

  function automatic logic [26:0] act27();
    return {ex_alu_op, ex_alu_sel, mem_read, wb_reg_write, ex_rd, mem_rd,
            wb_rd, stall, flush_ifid, fwd_a, fwd_b};
  endfunction

  function automatic logic [32:0] act33();
    return {ex_alu_op, ex_alu_sel, ex_addr_sel, mem_read, mem_write,
            wb_reg_write, wb_data_sel, ex_rd, mem_rd, wb_rd, stall,
            flush_ifid, fwd_a, fwd_b};
  endfunction

  task automatic check(input string name, input logic [39:0] act,
                       input logic [39:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [11:0] c, input int s1, input int s2,
                       input int d, input logic redir);
    ctrl_id = c; rs1_id = AW'(s1); rs2_id = AW'(s2); rd_id = AW'(d);
    redirect_ex = redir;
  endtask

  // ---------------- reference model ----------------
  // Instructions are records; the pipe is an array indexed by stage
  // (0 = EX, 1 = MEM, 2 = WB). Outputs are derived from the hazard rules.
  typedef struct {
    logic [11:0]   c;
    logic [AW-1:0] s1, s2, d;
  } instr_t;

  instr_t pipe[3];

  function automatic instr_t bubble();
    instr_t b;
    b.c = '0; b.s1 = '0; b.s2 = '0; b.d = '0;
    return b;
  endfunction

  function automatic bit writes(input instr_t p, input logic [AW-1:0] r);
    return p.c[11] && p.d != 0 && p.d == r;
  endfunction

  function automatic logic [1:0] src_of(input logic [AW-1:0] r);
    if (writes(pipe[1], r)) return 2'd1;
    if (writes(pipe[2], r)) return 2'd2;
    return 2'd0;
  endfunction

  function automatic bit load_use(input logic [AW-1:0] a, input logic [AW-1:0] b);
    return pipe[0].c[8] && pipe[0].d != 0 && (pipe[0].d == a || pipe[0].d == b);
  endfunction

  function automatic logic [32:0] model_out();
    bit hz;
    hz = load_use(rs1_id, rs2_id);
    return {pipe[0].c[3:1], pipe[0].c[0], pipe[0].c[6:4], pipe[1].c[8],
            pipe[1].c[7], pipe[2].c[11], pipe[2].c[10:9], pipe[0].d,
            pipe[1].d, pipe[2].d, 1'(hz && !redirect_ex), redirect_ex,
            src_of(pipe[0].s1), src_of(pipe[0].s2)};
  endfunction

  task automatic model_clock();
    instr_t n;
    bit hz;
    hz = load_use(rs1_id, rs2_id);
    n.c = ctrl_id; n.s1 = rs1_id; n.s2 = rs2_id; n.d = rd_id;
    pipe[2] = pipe[1];
    pipe[1] = pipe[0];
    pipe[0] = (redirect_ex || hz) ? bubble() : n;
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) pipe[k] = bubble();
  endtask

  initial begin
    logic [11:0] rc;
    logic        hold;
    rst_n = 1'b1;
    drive(NOP, 0, 0, 0, 1'b0);
    #1 rst_n = 1'b0;

    //            rst ctrl s1 s2 d  rdr  op sel mr wr erd mrd wrd st fl fa fb
    vecs[0]  = mk(0, ADD, 0, 0, 3, 0,   0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0);
    vecs[1]  = mk(1, ADD, 1, 2, 3, 0,   0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0);
    vecs[2]  = mk(1, NOP, 0, 0, 0, 0,   1, 1, 0, 0, 3,  0,  0,  0, 0, 0, 0);
    vecs[3]  = mk(1, NOP, 0, 0, 0, 0,   0, 0, 0, 0, 0,  3,  0,  0, 0, 0, 0);
    vecs[4]  = mk(1, ADD, 1, 2, 5, 0,   0, 0, 0, 1, 0,  0,  3,  0, 0, 0, 0);
    vecs[5]  = mk(1, ADD, 5, 5, 6, 0,   1, 1, 0, 0, 5,  0,  0,  0, 0, 0, 0);
    vecs[6]  = mk(1, ADD, 1, 2, 9, 0,   1, 1, 0, 0, 6,  5,  0,  0, 0, 1, 1);
    vecs[7]  = mk(1, ADD, 1, 2, 10, 0,  1, 1, 0, 1, 9,  6,  5,  0, 0, 0, 0);
    vecs[8]  = mk(1, ADD, 1, 2, 11, 0,  1, 1, 0, 1, 10, 9,  6,  0, 0, 0, 0);
    vecs[9]  = mk(1, ADD, 10, 10, 12, 0, 1, 1, 0, 1, 11, 10, 9, 0, 0, 0, 0);
    vecs[10] = mk(1, NOP, 0, 0, 0, 0,   1, 1, 0, 1, 12, 11, 10, 0, 0, 2, 2);
    vecs[11] = mk(1, LW,  1, 2, 7, 0,   0, 0, 0, 1, 0,  12, 11, 0, 0, 0, 0);
    vecs[12] = mk(1, ADD, 7, 2, 13, 0,  1, 0, 0, 1, 7,  0,  12, 1, 0, 0, 0);
    vecs[13] = mk(1, ADD, 7, 2, 13, 0,  0, 0, 1, 0, 0,  7,  0,  0, 0, 0, 0);
    vecs[14] = mk(1, NOP, 0, 0, 0, 0,   1, 1, 0, 1, 13, 0,  7,  0, 0, 2, 0);
    vecs[15] = mk(1, ADD, 1, 2, 14, 1,  0, 0, 0, 0, 0,  13, 0,  0, 1, 0, 0);
    vecs[16] = mk(1, NOP, 0, 0, 0, 0,   0, 0, 0, 1, 0,  0,  13, 0, 0, 0, 0);
    vecs[17] = mk(1, LW,  1, 2, 4, 0,   0, 0, 0, 0, 0,  0,  0,  0, 0, 0, 0);
    vecs[18] = mk(1, ADD, 4, 2, 15, 1,  1, 0, 0, 0, 4,  0,  0,  0, 1, 0, 0);
    vecs[19] = mk(1, NOP, 0, 0, 0, 0,   0, 0, 1, 0, 0,  4,  0,  0, 0, 0, 0);
    vecs[20] = mk(1, ADD, 1, 2, 0, 0,   0, 0, 0, 1, 0,  0,  4,  0, 0, 0, 0);
    vecs[21] = mk(1, ADD, 0, 0, 16, 0,  1, 1, 0, 0, 0,  0,  0,  0, 0, 0, 0);
    vecs[22] = mk(1, NOP, 0, 0, 0, 0,   1, 1, 0, 0, 16, 0,  0,  0, 0, 0, 0);
    vecs[23] = mk(1, LW,  1, 2, 0, 0,   0, 0, 0, 1, 0,  16, 0,  0, 0, 0, 0);
    vecs[24] = mk(1, ADD, 0, 0, 17, 0,  1, 0, 0, 1, 0,  0,  16, 0, 0, 0, 0);
    vecs[25] = mk(1, ADD, 3, 3, 18, 0,  1, 1, 1, 0, 17, 0,  0,  0, 0, 0, 0);

    for (int i = 0; i < NV; i++) begin
      @(negedge clk);
      rst_n = vecs[i].rst;
      drive(vecs[i].c, int'(vecs[i].s1), int'(vecs[i].s2), int'(vecs[i].d),
            vecs[i].redir);
      #2;
      check($sformatf("vec%0d", i), 40'(act27()), 40'(vecs[i].exp));
    end

    // Mid-operation reset: EX=add18, MEM=add17, WB=lw rd0 before the pulse.
    @(negedge clk);
    drive(ADD, 1, 2, 20, 1'b0);
    #1;
    check("pre_reset", 40'({ex_rd, mem_rd, wb_reg_write, wb_data_sel}),
          40'({5'd18, 5'd17, 1'b1, 2'b10}));
    rst_n = 1'b0;
    #1;
    check("async_clear", 40'(act33()), 40'd0);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_rst_e1", 40'({ex_alu_op, ex_rd, mem_rd, wb_reg_write}),
          40'({3'd1, 5'd20, 5'd0, 1'b0}));
    drive(NOP, 0, 0, 0, 1'b0);
    @(posedge clk); #1;
    check("post_rst_e2", 40'({ex_rd, mem_rd, wb_reg_write}),
          40'({5'd0, 5'd20, 1'b0}));
    @(posedge clk); #1;
    check("post_rst_e3", 40'({wb_reg_write, wb_rd}), 40'({1'b1, 5'd20}));

    // ---------------- randomized phase ----------------
    @(negedge clk);
    rst_n = 1'b0;
    #1 rst_n = 1'b1;
    model_reset();
    hold = 1'b0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      if ($urandom_range(0, 49) == 0) begin
        rst_n = 1'b0;
        drive(ADD, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), 1'b0);
        hold = 1'b0;
        model_reset();
        #2;
        check($sformatf("rnd_rst%0d", cyc), 40'(act33()), 40'(model_out()));
        // reset held over the edge: stages stay bubbles
        continue;
      end
      rst_n = 1'b1;
      if (!hold) begin
        case ($urandom_range(0, 3))
          0: rc = ADD;
          1: rc = LW;
          2: rc = NOP;
          default: rc = 12'($urandom);
        endcase
        drive(rc, $urandom_range(0, 7), $urandom_range(0, 7),
              $urandom_range(0, 7), 1'b0);
      end
      redirect_ex = ($urandom_range(0, 9) == 0);
      #2;
      check($sformatf("rnd%0d", cyc), 40'(act33()), 40'(model_out()));
      hold = load_use(rs1_id, rs2_id) && !redirect_ex;
      model_clock();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
